// File: rtl/fsm_rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter slice.
package fsm_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_GRANT,
    ARB_RELEASE
  } arb_state_e;

  // Width of an index or counter that must hold values 0..n-1, never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fsm_rr_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface fsm_rr_arbiter_if #(
  parameter int N = 4
);
  import fsm_arb_pkg::*;

  localparam int IW = idx_w(N);

  logic [N-1:0]  req;
  logic [N-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          idle;
  logic          busy;
  logic          timeout;

  modport master (
    output req,
    input  gnt, gnt_id, idle, busy, timeout
  );

  modport slave (
    input  req,
    output gnt, gnt_id, idle, busy, timeout
  );
endinterface

// File: rtl/fsm_rr_arbiter_pick.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_pick
  import fsm_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]        req,
  input  logic [idx_w(N)-1:0] ptr,
  output logic                valid,
  output logic [idx_w(N)-1:0] idx
);
  localparam int IW = idx_w(N);

  int j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = IW'(j);
      end
    end
  end
endmodule

// File: rtl/fsm_rr_arbiter.sv
// Round-robin arbiter with per-owner hold timeout and turnaround gap; all outputs registered.
module fsm_rr_arbiter
  import fsm_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_HOLD = 15,
  parameter int GAP_CYC  = 1
) (
  input  logic          clk,
  input  logic          reset,
  fsm_rr_arbiter_if.slave bus
);
  localparam int IW = idx_w(N);
  localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  arb_state_e    state_q, state_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] gnt_id_q, gnt_id_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          idle_q, idle_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          pick_valid;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_next;

  rr_pick #(.N(N)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign ptr_next = (int'(gnt_id_q) == N - 1) ? '0 : gnt_id_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    gnt_id_d  = gnt_id_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d          = ARB_GRANT;
          gnt_d            = '0;
          gnt_d[pick_idx]  = 1'b1;
          gnt_id_d         = pick_idx;
          hold_d           = '0;
        end
      end
      ARB_GRANT: begin
        // Owner drop takes precedence, so a drop on the limit cycle never pulses timeout.
        if (!bus.req[gnt_id_q]) begin
          state_d = ARB_RELEASE;
          gnt_d   = '0;
          gap_d   = '0;
          ptr_d   = ptr_next;
        end else if (MAX_HOLD != 0 && hold_q == HW'(MAX_HOLD - 1)) begin
          state_d   = ARB_RELEASE;
          gnt_d     = '0;
          gap_d     = '0;
          ptr_d     = ptr_next;
          timeout_d = 1'b1;
        end else if (MAX_HOLD != 0) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ARB_RELEASE: begin
        if (gap_q == GW'(GAP_CYC - 1)) begin
          if (pick_valid) begin
            state_d         = ARB_GRANT;
            gnt_d           = '0;
            gnt_d[pick_idx] = 1'b1;
            gnt_id_d        = pick_idx;
            hold_d          = '0;
          end else begin
            state_d = ARB_IDLE;
          end
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    idle_d = (state_d == ARB_IDLE);
    busy_d = ~idle_d;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      gnt_q     <= '0;
      gnt_id_q  <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      gap_q     <= '0;
      idle_q    <= 1'b1;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_id_q  <= gnt_id_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      idle_q    <= idle_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = gnt_id_q;
  assign bus.idle    = idle_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_fsm_rr_arbiter.sv
// Directed, table-driven bench for fsm_rr_arbiter with N=4, MAX_HOLD=4, GAP_CYC=1.
module tb_fsm_rr_arbiter;
  logic clk;
  logic reset;

  fsm_rr_arbiter_if #(.N(4)) bus ();

  fsm_rr_arbiter #(
    .N        (4),
    .MAX_HOLD (4),
    .GAP_CYC  (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       idle;
    logic       to;
  } vec_t;

  vec_t vecs[$];
  int   n_vec;
  int   n_err;

  task automatic add(input logic r, input logic [3:0] rq, input logic [3:0] g,
                     input logic [1:0] id, input logic i, input logic t);
    vec_t v;
    v.rst_n = r; v.req = rq; v.gnt = g; v.id = id; v.idle = i; v.to = t;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] eg,
                      input logic [1:0] eid, input logic ei, input logic et,
                      input string tag);
    reset   = r;
    bus.req = rq;
    @(posedge clk);
    #1;
    n_vec++;
    if (bus.gnt !== eg) begin
      n_err++;
      $display("FAIL %s gnt: got %b want %b", tag, bus.gnt, eg);
    end
    if (bus.gnt_id !== eid) begin
      n_err++;
      $display("FAIL %s gnt_id: got %0d want %0d", tag, bus.gnt_id, eid);
    end
    if (bus.idle !== ei) begin
      n_err++;
      $display("FAIL %s idle: got %b want %b", tag, bus.idle, ei);
    end
    if (bus.busy !== ~ei) begin
      n_err++;
      $display("FAIL %s busy: got %b want %b", tag, bus.busy, ~ei);
    end
    if (bus.timeout !== et) begin
      n_err++;
      $display("FAIL %s timeout: got %b want %b", tag, bus.timeout, et);
    end
  endtask

  initial begin
    logic [3:0] oh;
    n_vec   = 0;
    n_err   = 0;
    reset   = 1'b0;
    bus.req = '0;

    // Reset held two edges with all requests up
    add(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0);
    add(1'b0, 4'b1111, 4'b0000, 2'd0, 1'b1, 1'b0);
    // Full rotation with all requesters: 4-wide grants, timeout, one gap cycle
    for (int g = 0; g < 4; g++) begin
      oh = 4'b0001 << g;
      for (int c = 0; c < 4; c++) add(1'b1, 4'b1111, oh, 2'(g), 1'b0, 1'b0);
      add(1'b1, 4'b1111, 4'b0000, 2'(g), 1'b0, 1'b1);
    end
    add(1'b1, 4'b1111, 4'b0001, 2'd0, 1'b0, 1'b0);
    // Owner drops: release then idle, gnt_id held
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
    // Single requester, voluntary drop after two grant cycles
    add(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
    add(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].gnt, vecs[i].id, vecs[i].idle,
           vecs[i].to, $sformatf("vec%0d", i));
    end

    // Priority rotation: id 1 times out (ptr=2), then 3 wins over 1, then 1 again
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "rot_rst");
    step(1'b1, 4'b0010, 4'b0010, 2'd1, 1'b0, 1'b0, "rot_g1");
    for (int c = 0; c < 3; c++) step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b0, "rot_hold1");
    step(1'b1, 4'b1010, 4'b0000, 2'd1, 1'b0, 1'b1, "rot_to1");
    for (int c = 0; c < 4; c++) step(1'b1, 4'b1010, 4'b1000, 2'd3, 1'b0, 1'b0, "rot_g3");
    step(1'b1, 4'b1010, 4'b0000, 2'd3, 1'b0, 1'b1, "rot_to3");
    step(1'b1, 4'b1010, 4'b0010, 2'd1, 1'b0, 1'b0, "rot_g1b");
    step(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0, "rot_rel");
    step(1'b1, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, "rot_idle");

    // Drop coinciding with the hold limit: normal release, no pulse
    step(1'b0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "lim_rst");
    for (int c = 0; c < 4; c++) step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, "lim_g2");
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b0, 1'b0, "lim_drop");
    step(1'b1, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, "lim_idle");

    // Reset during a grant clears ptr; next pick starts from 0
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, "mr_g2a");
    step(1'b1, 4'b0100, 4'b0100, 2'd2, 1'b0, 1'b0, "mr_g2b");
    step(1'b0, 4'b0100, 4'b0000, 2'd0, 1'b1, 1'b0, "mr_rst");
    step(1'b1, 4'b1001, 4'b0001, 2'd0, 1'b0, 1'b0, "mr_g0");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0, "mr_rel");
    step(1'b1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, "mr_idle");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
